gf_divider_seq: RTL
===================

Name: gf_divider_seq

Overview:
- Sequential GF(2^m) divider for the Reed-Solomon datapath. Computes quotient = op_a / op_b = op_a * op_b^(2^m-2) by Fermat inversion with square-and-multiply, one GF multiply per clock.
- Inverse companion of the combinational GF multiplier. Used by the RS decoder for error-magnitude (Forney) division.
- Single shared internal multiply stage, using the same polynomial reduction as the multiplier.

Parameters:
- m, 8, symbol width in bits.
- POLY, 9'h11D, primitive field polynomial, including the x^m term. Must match the multiplier's field.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled only when busy=0.
- op_a  input  m  dividend. Captured on the accepting edge.
- op_b  input  m  divisor. Captured on the accepting edge.
- busy  output  1  high while a division is in progress.
- done  output  1  single-cycle pulse. quotient and div_by_zero are valid while it is high.
- div_by_zero  output  1  high when the completed request had op_b=0. Held until the next accepted start.
- quotient  output  m  result. Held until the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - busy=0, done=0, div_by_zero=0, quotient=0.
  - Internal a_reg, b_reg, r, cnt cleared.
  - Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, SQR, MUL, FSQ, MULA.
- IDLE:
  - On the edge with start=1 and op_b!=0: a_reg<=op_a, b_reg<=op_b, r<=op_b, cnt<=0, div_by_zero<=0, busy<=1, state<=SQR.
  - On the edge with start=1 and op_b=0: quotient<=0, div_by_zero<=1, done<=1. Stays IDLE and busy stays 0, so latency is 1 cycle.
- SQR: r<=r*r, state<=MUL.
- MUL:
  - r<=r*b_reg, cnt<=cnt+1.
  - If cnt==m-3, state<=FSQ; else state<=SQR.
  - This gives m-2 SQR/MUL pairs, so r=b^(2^(m-1)-1).
- FSQ: r<=r*r, so r=b^(2^m-2)=b^-1. state<=MULA.
- MULA: quotient<=a_reg*r, done<=1, busy<=0, state<=IDLE.
- Latency:
  - Valid division: exactly 2m-2 edges after the accepting edge (14 for m=8).
  - done is high for exactly one cycle following that edge.
  - Timing is constant and data-independent, including op_a=0.
- Throughput: a new start is accepted in the same cycle done is high, since state is IDLE. Back-to-back requests therefore issue every 2m-1 cycles.
- start while busy=1 is ignored, not queued. op_a/op_b changes while busy do not affect the result.
- done is low in every cycle other than the completion pulse.
- GF multiply:
  - Carry-less m x m product, reduced modulo POLY.
  - Purely combinational within the cycle; no extra pipeline stage.
- Counter cnt: ceil(log2(m-2)) bits minimum. It never wraps in legal operation.

Test Plan:
- Reset: hold rst_n=0, then release → all outputs 0. Assert rst_n low at cycle 5 of an active division → busy=0 immediately, no done pulse, next start works normally.
- Basic division (m=8, POLY=0x11D):
  - 0x53/0x01 → 0x53.
  - 0x04/0x02 → 0x02.
  - 0x1D/0x02 → 0x80.
  - 0x01/0x02 → 0x8E.
  - Each with done pulse exactly 14 cycles after the accepting edge and busy high for those 14 cycles.
- Divide by zero: 0x53/0x00 → done and div_by_zero=1 on the next cycle, quotient=0x00, busy never asserted. A following 0x53/0x01 clears div_by_zero.
- Zero dividend and constant timing: 0x00/0x57 → quotient 0x00 after exactly 14 cycles, div_by_zero=0.
- Handshake:
  - Pulse start again at cycles 3 and 10 of a busy operation with different operands → ignored, first result unchanged.
  - Assert start in the done cycle → accepted, second result 14 cycles later.
- Random round-trip: 1000 random pairs with op_b!=0 → the combinational multiplier's output for quotient*op_b equals op_a for every pair, and latency is always 14.

Source files
------------

// File: rtl/gf_divider_seq_if.sv
// Request/response bundle for the sequential GF(2^m) divider.
//   master: start, op_a, op_b out; busy, done, div_by_zero, quotient in
//   slave : the mirror image, used by gf_divider_seq
interface gf_divider_seq_if #(
  parameter int unsigned m = 8
);
  logic         start;
  logic [m-1:0] op_a;
  logic [m-1:0] op_b;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [m-1:0] quotient;

  modport master (
    output start, op_a, op_b,
    input  busy, done, div_by_zero, quotient
  );

  modport slave (
    input  start, op_a, op_b,
    output busy, done, div_by_zero, quotient
  );
endinterface

// File: rtl/gf_divider_seq.sv
// Sequential GF(2^m) divider: quotient = op_a * op_b^(2^m-2), i.e. a Fermat
// inversion by square-and-multiply followed by one multiply with the dividend.
// Exactly one GF multiply is evaluated per clock through a single shared
// carry-less multiply/reduce stage.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of gf_divider_seq_if (start/op_a/op_b in,
//           busy/done/div_by_zero/quotient out, all outputs registered)
// Latency: 2m-2 edges after the accepting edge for op_b!=0, 1 cycle for op_b=0.
module gf_divider_seq #(
  parameter int unsigned m    = 8,
  parameter logic [m:0]  POLY = 9'h11D
) (
  input  logic            clk,
  input  logic            rst_n,
  gf_divider_seq_if.slave bus
);

  localparam int unsigned     CW       = (m > 3) ? $clog2(m - 2) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(m - 3);

  typedef enum logic [2:0] {IDLE, SQR, MUL, FSQ, MULA} state_t;

  state_t         state_q, state_d;
  logic [m-1:0]   a_reg_q, a_reg_d;
  logic [m-1:0]   b_reg_q, b_reg_d;
  logic [m-1:0]   r_q, r_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;
  logic [m-1:0]   quo_q, quo_d;

  logic [m-1:0]   mul_x, mul_y, mul_p;

  // Shift-and-add multiply with the reduction folded into each doubling of x.
  function automatic logic [m-1:0] gf_mul(input logic [m-1:0] x, input logic [m-1:0] y);
    logic [m-1:0] acc;
    logic [m-1:0] xs;
    acc = '0;
    xs  = x;
    for (int unsigned i = 0; i < m; i++) begin
      if (y[i]) acc = acc ^ xs;
      xs = xs[m-1] ? ((xs << 1) ^ POLY[m-1:0]) : (xs << 1);
    end
    return acc;
  endfunction

  // Shared multiplier operands: squaring uses r*r, MUL uses r*b, MULA uses a*r.
  always_comb begin
    mul_x = (state_q == MULA) ? a_reg_q : r_q;
    mul_y = (state_q == MUL)  ? b_reg_q : r_q;
  end

  assign mul_p = gf_mul(mul_x, mul_y);

  always_comb begin
    state_d = state_q;
    a_reg_d = a_reg_q;
    b_reg_d = b_reg_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quo_d   = quo_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.op_b != '0) begin
            a_reg_d = bus.op_a;
            b_reg_d = bus.op_b;
            r_d     = bus.op_b;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = SQR;
          end else begin
            quo_d  = '0;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      SQR: begin
        r_d     = mul_p;
        state_d = MUL;
      end
      MUL: begin
        r_d     = mul_p;
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CNT_LAST) ? FSQ : SQR;
      end
      FSQ: begin
        // After m-2 square/multiply pairs r = b^(2^(m-1)-1); one more squaring gives b^-1.
        r_d     = mul_p;
        state_d = MULA;
      end
      MULA: begin
        quo_d   = mul_p;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_reg_q <= '0;
      b_reg_q <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
    end else begin
      state_q <= state_d;
      a_reg_q <= a_reg_d;
      b_reg_q <= b_reg_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quo_q   <= quo_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.quotient    = quo_q;

endmodule
